// File: rtl/vending_pkg.sv
// Shared coin encoding, coin values in cents and dispenser FSM states.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'd0,
    COIN_DIME    = 2'd1,
    COIN_QUARTER = 2'd2,
    COIN_DOLLAR  = 2'd3
  } coin_e;

  localparam logic [6:0] VAL_NICKEL  = 7'd5;
  localparam logic [6:0] VAL_DIME    = 7'd10;
  localparam logic [6:0] VAL_QUARTER = 7'd25;
  localparam logic [6:0] VAL_DOLLAR  = 7'd100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  function automatic logic [6:0] coin_value(input logic [1:0] code);
    logic [6:0] v;
    case (code)
      COIN_NICKEL:  v = VAL_NICKEL;
      COIN_DIME:    v = VAL_DIME;
      COIN_QUARTER: v = VAL_QUARTER;
      COIN_DOLLAR:  v = VAL_DOLLAR;
      default:      v = VAL_NICKEL;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin choice for a given remainder. Macro DOLLAR_COIN_EN makes the
// 100-cent coin eligible; otherwise the quarter is the largest coin.
module coin_select
  import vending_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_remainder,
  output logic [1:0]       o_coin_type,
  output logic [WIDTH-1:0] o_coin_value,
  output logic             o_invalid
);

  logic [1:0] w_type;

  // Largest eligible coin not exceeding the remainder
  always_comb begin
    w_type = COIN_NICKEL;
`ifdef DOLLAR_COIN_EN
    if (i_remainder >= WIDTH'(VAL_DOLLAR)) begin
      w_type = COIN_DOLLAR;
    end else if (i_remainder >= WIDTH'(VAL_QUARTER)) begin
      w_type = COIN_QUARTER;
    end else if (i_remainder >= WIDTH'(VAL_DIME)) begin
      w_type = COIN_DIME;
    end else begin
      w_type = COIN_NICKEL;
    end
`else
    if (i_remainder >= WIDTH'(VAL_QUARTER)) begin
      w_type = COIN_QUARTER;
    end else if (i_remainder >= WIDTH'(VAL_DIME)) begin
      w_type = COIN_DIME;
    end else begin
      w_type = COIN_NICKEL;
    end
`endif
  end

  assign o_coin_type  = w_type;
  assign o_coin_value = WIDTH'(coin_value(w_type));
  // A non-zero remainder below the smallest coin cannot be paid out
  assign o_invalid    = (i_remainder != '0) && (i_remainder < WIDTH'(VAL_NICKEL));

endmodule

// File: rtl/change_dispenser.sv
// Dispenses a change amount as a greedy sequence of coins through a
// valid/ready hopper handshake. Macro DOLLAR_COIN_EN enables the dollar coin.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int COIN_GAP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [WIDTH-1:0] change,
  output logic             busy,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  input  logic             coin_ready,
  output logic [WIDTH-1:0] remainder,
  output logic [7:0]       coin_count,
  output logic             done,
  output logic             error
);

  localparam int GW = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (COIN_GAP > 0) ? GW'(COIN_GAP - 1) : '0;

  state_e           r_state;
  logic             r_busy;
  logic             r_coin_valid;
  logic [1:0]       r_coin_type;
  logic [WIDTH-1:0] r_coin_value;
  logic [WIDTH-1:0] r_remainder;
  logic [7:0]       r_coin_count;
  logic             r_done;
  logic             r_error;
  logic [GW-1:0]    r_gap_cnt;

  logic [1:0]       w_sel_type;
  logic [WIDTH-1:0] w_sel_value;
  logic             w_invalid;

  coin_select #(.WIDTH(WIDTH)) u_coin_select (
    .i_remainder  (r_remainder),
    .o_coin_type  (w_sel_type),
    .o_coin_value (w_sel_value),
    .o_invalid    (w_invalid)
  );

  // Dispenser FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_coin_valid <= 1'b0;
      r_coin_type  <= 2'd0;
      r_coin_value <= '0;
      r_remainder  <= '0;
      r_coin_count <= 8'd0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (change_valid) begin
            if (change != '0) begin
              r_remainder  <= change;
              r_coin_count <= 8'd0;
              r_busy       <= 1'b1;
              r_state      <= ST_SELECT;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_SELECT: begin
          if (r_remainder == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_invalid) begin
            r_error     <= 1'b1;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_coin_type  <= w_sel_type;
            r_coin_value <= w_sel_value;
            r_coin_valid <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (coin_ready) begin
            // Selection guarantees the coin value never exceeds the remainder
            r_remainder  <= r_remainder - r_coin_value;
            r_coin_count <= (r_coin_count == 8'd255) ? 8'd255 : r_coin_count + 8'd1;
            r_coin_valid <= 1'b0;
            if (COIN_GAP == 0) begin
              r_state <= ST_SELECT;
            end else begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_SELECT;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_coin_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign coin_valid = r_coin_valid;
  assign coin_type  = r_coin_type;
  assign remainder  = r_remainder;
  assign coin_count = r_coin_count;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser with a greedy reference model.
module tb_change_dispenser;

  localparam int WIDTH    = 16;
  localparam int COIN_GAP = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             change_valid = 1'b0;
  logic [WIDTH-1:0] change = '0;
  logic             coin_ready;
  logic             busy, coin_valid, done, error;
  logic [1:0]       coin_type;
  logic [WIDTH-1:0] remainder;
  logic [7:0]       coin_count;

  change_dispenser #(.WIDTH(WIDTH), .COIN_GAP(COIN_GAP)) dut (
    .clk(clk), .reset(reset), .change_valid(change_valid), .change(change),
    .busy(busy), .coin_valid(coin_valid), .coin_type(coin_type),
    .coin_ready(coin_ready), .remainder(remainder), .coin_count(coin_count),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 0 coin, 1 done, 2 error
    int val;   // coin type, or coin count for done/error
    int rem;   // remainder expected when the event is seen
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  last_count = 0;
  int  ready_mode = 1;  // 0 low, 1 high, 2 random

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: greedy payout from plain arithmetic
  task automatic model_push(input int amount);
    int rem, cnt, v, t;
    ev_t e;
    if (amount == 0) begin
      e.kind = 1; e.val = last_count; e.rem = 0;
      exp_q.push_back(e);
      return;
    end
    rem = amount; cnt = 0;
    while (rem >= 5) begin
`ifdef DOLLAR_COIN_EN
      if (rem >= 100) begin v = 100; t = 3; end
      else
`endif
      if (rem >= 25) begin v = 25; t = 2; end
      else if (rem >= 10) begin v = 10; t = 1; end
      else begin v = 5; t = 0; end
      e.kind = 0; e.val = t; e.rem = rem;
      exp_q.push_back(e);
      rem -= v; cnt++;
    end
    e.kind = (rem == 0) ? 1 : 2; e.val = (cnt > 255) ? 255 : cnt; e.rem = 0;
    exp_q.push_back(e);
    last_count = e.val;
  endtask

  // Hopper ready driver
  initial begin
    coin_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 2) coin_ready = ($urandom_range(0, 9) < 7);
      else coin_ready = (ready_mode == 1);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    int since_hs = -1;
    bit prev_cv = 1'b0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        since_hs = -1; prev_cv = 1'b0;
      end else begin
        if (coin_valid && !prev_cv && since_hs >= 0)
          check("coin_gap_ok", int'(since_hs >= COIN_GAP), 1);
        if (!coin_valid && since_hs >= 0) since_hs++;
        if (coin_valid && coin_ready) begin
          if (exp_q.size() == 0) check("unexpected_coin", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("coin_kind", 0, e.kind);
            check("coin_type", int'(coin_type), e.val);
            check("coin_remainder", int'(remainder), e.rem);
          end
          since_hs = 0;
        end
        if (done || error) begin
          if (exp_q.size() == 0) check("unexpected_end", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("end_kind", done ? 1 : 2, e.kind);
            check("end_count", int'(coin_count), e.val);
            check("end_remainder", int'(remainder), 0);
          end
          since_hs = -1;
        end
        prev_cv = coin_valid;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_cv();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (coin_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("coin_valid_timeout", 0, 1);
  endtask

  task automatic start_req(input int amount, input bit push);
    @(posedge clk); #1;
    change_valid = 1'b1;
    change = WIDTH'(amount);
    if (push) model_push(amount);
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    change_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_coin_valid"}, int'(coin_valid), 0);
    check({tag, "_coin_type"}, int'(coin_type), 0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_coin_count"}, int'(coin_count), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_error"}, int'(error), 0);
  endtask

  initial begin
    int v;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // 65 cents: latency and Q,Q,D,N ordering
    start_req(65, 1'b1);
    @(negedge clk);
    check("lat_n_busy", int'(busy), 0);
    end_req();
    @(negedge clk);
    check("lat_n1_busy", int'(busy), 1);
    check("lat_n1_cv", int'(coin_valid), 0);
    @(negedge clk);
    check("lat_n2_cv", int'(coin_valid), 1);
    check("lat_n2_type", int'(coin_type), 2);
    wait_idle();
    check("c65_count", int'(coin_count), 4);

    start_req(50, 1'b1); end_req(); wait_idle();
    check("c50_count", int'(coin_count), 2);
    check("c50_remainder", int'(remainder), 0);

    start_req(200, 1'b1); end_req(); wait_idle();
`ifdef DOLLAR_COIN_EN
    check("c200_count", int'(coin_count), 2);
`else
    check("c200_count", int'(coin_count), 8);
`endif

    // 3 cents: error two cycles after the request, no coin
    start_req(3, 1'b1);
    end_req();
    @(negedge clk);
    check("err_n1_error", int'(error), 0);
    check("err_n1_cv", int'(coin_valid), 0);
    @(negedge clk);
    check("err_n2_error", int'(error), 1);
    check("err_n2_cv", int'(coin_valid), 0);
    check("err_n2_remainder", int'(remainder), 0);
    wait_idle();

    start_req(0, 1'b1); end_req(); wait_idle();

    // 25 cents with the hopper stalled
    ready_mode = 0;
    start_req(25, 1'b1); end_req();
    wait_cv();
    for (int i = 0; i < 10; i++) begin
      check("stall_cv", int'(coin_valid), 1);
      check("stall_type", int'(coin_type), 2);
      check("stall_remainder", int'(remainder), 25);
      @(negedge clk);
    end
    ready_mode = 1;
    wait_idle();
    check("stall_count", int'(coin_count), 1);

    // 100 cents, extra request while busy, reset in second ISSUE cycle
    ready_mode = 0;
    start_req(100, 1'b0);
    @(posedge clk); #1;
    change = WIDTH'(40);
    end_req();
    wait_cv();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    ready_mode = 1;
    repeat (5) @(negedge clk);
    check("midreset_idle_busy", int'(busy), 0);
    last_count = 0;

    // Randomized requests with random hopper readiness and busy-time noise
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      wait_idle();
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 330));
      start_req(v, 1'b1);
      end_req();
      if (v >= 5 && $urandom_range(0, 1) == 1) begin
        wait_cv();
        start_req(int'($urandom_range(1, 300)), 1'b0);
        end_req();
      end
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter WIDTH, default 16, width of the change and remainder values in cents.
REQ-002 Parameter COIN_GAP, default 2, idle cycles enforced between accepted coins (0 allowed).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 change_valid  input  1  change request strobe from vending_machine.
REQ-006 change  input  WIDTH  change amount in cents, sampled when change_valid=1.
REQ-007 busy  output  1  high while a request is being dispensed.
REQ-008 coin_valid  output  1  a coin is offered to the hopper.
REQ-009 coin_type  output  2  coin code: 0 nickel (5), 1 dime (10), 2 quarter (25), 3 dollar (100).
REQ-010 coin_ready  input  1  hopper accepts the offered coin this cycle.
REQ-011 remainder  output  WIDTH  cents still owed.
REQ-012 coin_count  output  8  coins accepted in the current or last transaction (saturates at 255).
REQ-013 done  output  1  one-cycle pulse when a request completes.
REQ-014 error  output  1  one-cycle pulse when the remainder is not a multiple of 5.

Function
REQ-015 FSM states: IDLE, SELECT, ISSUE, GAP.
REQ-016 IDLE: busy=0; on change_valid=1 with change!=0, latch change into remainder, clear coin_count, and enter SELECT.
REQ-017 IDLE with change_valid=1 and change=0: pulse done in the next cycle and remain in IDLE.
REQ-018 A change_valid received while busy=1 is ignored; it is not queued.
REQ-019 SELECT: remainder=0 leads to a done pulse and IDLE.
REQ-020 SELECT: remainder 1-4 leads to an error pulse, remainder cleared to 0, and IDLE.
REQ-021 SELECT otherwise picks the largest enabled coin not exceeding remainder (greedy), registers coin_type, and enters ISSUE.
REQ-022 ISSUE: coin_valid=1; coin_type is held stable until coin_ready=1.
REQ-023 On the coin_valid & coin_ready cycle: subtract the coin value from remainder and increment coin_count. Next state is GAP, or SELECT when COIN_GAP=0.
REQ-024 GAP: coin_valid=0; after COIN_GAP cycles, enter SELECT.
REQ-025 Latency: change_valid in cycle N gives first coin_valid=1 in cycle N+2.
REQ-026 The subtraction never underflows, because the coin value is at most the remainder by construction.
REQ-027 busy=1 in SELECT, ISSUE and GAP.

Reset
REQ-028 reset has priority over all inputs. Next cycle: state IDLE, busy=0, coin_valid=0, coin_type=0, remainder=0, coin_count=0, done=0, error=0.
REQ-029 reset during ISSUE or GAP drops the pending coin and the owed remainder, with no done and no error pulse.

Configuration
REQ-030 With DOLLAR_COIN_EN defined, coin_type 3 (100 cents) is eligible in SELECT.
REQ-031 Without DOLLAR_COIN_EN, the largest coin is the quarter and coin_type never equals 3.

Structure
REQ-032 Shared package vending_pkg holds the coin_type encoding, the coin values in cents (5/10/25/100), and the FSM state enum.
REQ-033 Greedy selection lives in a combinational sub-module coin_select (remainder in; coin_type, coin value and invalid out).

Verification
REQ-034 change=50, coin_ready=1 always: two quarters, coin_count=2, done pulses, remainder=0.
REQ-035 change=65: coins Q, Q, D, N in that order, each separated by COIN_GAP idle cycles; coin_count=4.
REQ-036 change=200: with DOLLAR_COIN_EN, two type-3 coins; without it, eight quarters.
REQ-037 change=3: no coin_valid, error pulses in cycle N+2, remainder=0, done never asserted.
REQ-038 change=25 with coin_ready held 0 for 10 cycles: coin_valid and coin_type=2 stay stable, remainder stays 25; completes when coin_ready rises.
REQ-039 change=100, reset in the second ISSUE cycle: all outputs at reset values next cycle; a new change_valid during busy is ignored.
